ps2_link_sched: RTL and testbench
=================================

Name: ps2_link_sched

Overview:
Owns the shared PS/2 clock/data pair and sequences the PS/2 receiver and transmitter around it.
- Receive: enables the receiver and captures each received byte into a valid/ack holding register.
- Transmit: performs the host request-to-send sequence (inhibit clock, pull data, release clock), then starts the transmitter.
- Recovery: a watchdog abandons stalled frames by clearing the receiver bit counter.

Parameters:
INHIBIT_CYC, 5000, cycles the clock line is held low before RTS (100 us at 50 MHz).
RTS_CYC, 10, cycles data and clock are both held low before the clock is released.
TIMEOUT_CYC, 100000, maximum cycles between consecutive fall_edge pulses inside a frame, or from tx_start to tx_done.
CNT_W, 17, timer width; must hold max(INHIBIT_CYC, TIMEOUT_CYC).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
fall_edge  in  1  one-cycle pulse on a PS/2 clock falling edge, from the edge detector
rx_done  in  1  receiver frame-complete pulse
rx_data  in  8  receiver byte, valid with rx_done
tx_req  in  1  level; host requests a byte send
tx_data  in  8  byte to send, sampled when tx_req is accepted
tx_done  in  1  transmitter frame-complete pulse
tx_ack  out  1  one-cycle pulse when tx_req is accepted
tx_start  out  1  one-cycle pulse to the transmitter
tx_byte  out  8  latched tx_data
tx_idle  out  1  1 only in IDLE/RX_ACTIVE; gates the receiver
ps2_c_oe  out  1  1 = drive PS/2 clock low
ps2_d_oe  out  1  1 = drive PS/2 data low (RTS phase only)
resetCbits  out  1  one-cycle clear of the receiver bit counter
rx_byte  out  8  last received byte
rx_valid  out  1  rx_byte holds unread data
rx_ack  in  1  consumer read strobe; clears rx_valid
overrun  out  1  sticky; set when rx_done arrives while rx_valid=1
frame_err  out  1  one-cycle pulse on a watchdog timeout

Behaviour:
Reset values (rst sampled on a clk edge, wins over all events, any state):
- state=IDLE, timer=0.
- All outputs 0, except tx_idle=1.
- rx_byte=0, rx_valid=0, overrun=0.

States:
- IDLE: tx_idle=1.
  - fall_edge -> RX_ACTIVE, timer cleared.
  - Otherwise, if tx_req: tx_ack pulse, latch tx_byte -> INHIBIT.
  - fall_edge and tx_req in the same cycle: RX wins; tx_req stays pending.
- RX_ACTIVE: tx_idle=1; each fall_edge clears the timer.
  - rx_done -> IDLE.
  - timer reaches TIMEOUT_CYC-1 -> resetCbits and frame_err pulse, -> IDLE.
  - tx_req is ignored here and is served from IDLE the cycle after return.
- INHIBIT: ps2_c_oe=1 for exactly INHIBIT_CYC cycles -> RTS.
- RTS: ps2_c_oe=1 and ps2_d_oe=1 for exactly RTS_CYC cycles -> TX_WAIT.
- TX_WAIT:
  - Entry cycle: ps2_c_oe=0, ps2_d_oe=0, tx_start pulse, resetCbits pulse, timer cleared.
  - tx_done -> IDLE.
  - timeout -> frame_err pulse, -> IDLE.
  - fall_edge is ignored for RX purposes.
- tx_idle=0 in INHIBIT, RTS and TX_WAIT.
- tx_req is not re-accepted until the state is IDLE again; a held tx_req causes one new transfer per return to IDLE.

Receive capture and latency:
- rx_done at cycle N gives rx_byte=rx_data and rx_valid=1 at N+1.
- rx_done while rx_valid=1: overwrite rx_byte, set overrun.
- rx_ack clears rx_valid and overrun.
- rx_ack and rx_done in the same cycle: the new byte is captured, rx_valid stays 1, overrun is not set.
- rx_done is captured in any state (no gating).

Other rules:
- Timer is a saturating CNT_W-bit up-counter.
- tx_req in IDLE at cycle N: tx_ack at N, ps2_c_oe=1 from N+1; tx_start at N+1+INHIBIT_CYC+RTS_CYC.

Decomposition:
- Package ps2_link_pkg: state enum (IDLE, RX_ACTIVE, INHIBIT, RTS, TX_WAIT) and default timing constants.
- One natural sub-module, ps2_rx_holdreg: rx_byte, rx_valid, overrun, ack logic.
- The FSM and timer stay in the top level.

Test Plan (INHIBIT_CYC=8, RTS_CYC=2, TIMEOUT_CYC=20):
1. Reset mid-RTS -> next cycle state IDLE, ps2_c_oe=0, ps2_d_oe=0, tx_idle=1, rx_valid=0.
2. tx_req with tx_data=8'hED in IDLE at cycle 0 -> tx_ack at 0; ps2_c_oe=1 for cycles 1-10; ps2_d_oe=1 for cycles 9-10; tx_start and tx_byte=8'hED at cycle 11; tx_done at 30 -> tx_idle=1 at 31.
3. 11 fall_edges spaced 5 cycles, then rx_done with rx_data=8'hAA -> rx_byte=8'hAA and rx_valid=1 one cycle later; no frame_err.
4. fall_edge and tx_req in the same cycle -> RX_ACTIVE, no tx_ack; after rx_done the FSM returns to IDLE and tx_ack fires the following cycle.
5. 3 fall_edges then silence -> resetCbits and frame_err at the 20th cycle after the last edge; state IDLE.
6. Two rx_done (8'h11 then 8'h22) with no rx_ack -> rx_byte=8'h22, overrun=1; rx_ack -> rx_valid=0, overrun=0.

Source files
------------

// File: rtl/ps2_link_pkg.sv
// PS/2 link scheduler shared types and default timing.
// Timing defaults assume a 50 MHz system clock.
package ps2_link_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        RX_ACTIVE,
        INHIBIT,
        RTS,
        TX_WAIT
    } state_t;

    localparam int INHIBIT_CYC_DEF = 5000;
    localparam int RTS_CYC_DEF     = 10;
    localparam int TIMEOUT_CYC_DEF = 100000;
    localparam int CNT_W_DEF       = 17;

endpackage

// File: rtl/ps2_rx_holdreg.sv
// Holding register for received PS/2 bytes.
// Tracks unread data and sticky overrun.
module ps2_rx_holdreg
    import ps2_link_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rx_done,
    input  byte_t rx_data,
    input  logic  rx_ack,
    output byte_t rx_byte,
    output logic  rx_valid,
    output logic  overrun
);

    byte_t r_byte;
    logic  r_valid;
    logic  r_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (rx_done) begin
            // A same-cycle read consumes the old byte, so nothing is lost.
            r_byte  <= rx_data;
            r_valid <= 1'b1;
            r_ovr   <= rx_ack ? 1'b0 : (r_ovr | r_valid);
        end else if (rx_ack) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign rx_byte  = r_byte;
    assign rx_valid = r_valid;
    assign overrun  = r_ovr;

endmodule

// File: rtl/ps2_link_sched.sv
// PS/2 line owner: sequences receive frames, host RTS and
// transmit, with a watchdog that abandons stalled frames.
module ps2_link_sched
    import ps2_link_pkg::*;
#(
    parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
    parameter int RTS_CYC     = RTS_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  fall_edge,
    input  logic  rx_done,
    input  byte_t rx_data,
    input  logic  tx_req,
    input  byte_t tx_data,
    input  logic  tx_done,
    output logic  tx_ack,
    output logic  tx_start,
    output byte_t tx_byte,
    output logic  tx_idle,
    output logic  ps2_c_oe,
    output logic  ps2_d_oe,
    output logic  resetCbits,
    output byte_t rx_byte,
    output logic  rx_valid,
    input  logic  rx_ack,
    output logic  overrun,
    output logic  frame_err
);

    localparam logic [CNT_W-1:0] LP_INH_END = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] LP_RTS_END = CNT_W'(RTS_CYC - 1);
    localparam logic [CNT_W-1:0] LP_TMO_END = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    byte_t            r_tx_byte;
    logic             r_tx_start;
    logic             w_clr;
    logic             w_ack;
    logic             w_ferr;
    logic             w_rx_tmo;
    logic             w_start_nx;

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_ack      = 1'b0;
        w_ferr     = 1'b0;
        w_rx_tmo   = 1'b0;
        w_start_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A frame starting on the wire beats a pending send.
                if (fall_edge) begin
                    w_next = RX_ACTIVE;
                    w_clr  = 1'b1;
                end else if (tx_req) begin
                    w_ack  = 1'b1;
                    w_next = INHIBIT;
                    w_clr  = 1'b1;
                end
            end
            RX_ACTIVE: begin
                if (rx_done) begin
                    w_next = IDLE;
                end else if (fall_edge) begin
                    w_clr = 1'b1;
                end else if (r_timer == LP_TMO_END) begin
                    w_rx_tmo = 1'b1;
                    w_ferr   = 1'b1;
                    w_next   = IDLE;
                end
            end
            INHIBIT: begin
                if (r_timer == LP_INH_END) begin
                    w_next = RTS;
                    w_clr  = 1'b1;
                end
            end
            RTS: begin
                if (r_timer == LP_RTS_END) begin
                    w_next     = TX_WAIT;
                    w_clr      = 1'b1;
                    w_start_nx = 1'b1;
                end
            end
            TX_WAIT: begin
                if (tx_done) begin
                    w_next = IDLE;
                end else if (r_timer == LP_TMO_END) begin
                    w_ferr = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_tx_byte  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_start_nx;
            if (w_ack) r_tx_byte <= tx_data;
            if (w_clr) r_timer <= '0;
            else if (r_timer != '1) r_timer <= r_timer + 1'b1;
        end
    end

    assign tx_ack     = w_ack & ~rst;
    assign frame_err  = w_ferr & ~rst;
    assign resetCbits = r_tx_start | (w_rx_tmo & ~rst);
    assign tx_start   = r_tx_start;
    assign tx_byte    = r_tx_byte;
    assign tx_idle    = (r_state == IDLE) || (r_state == RX_ACTIVE);
    assign ps2_c_oe   = (r_state == INHIBIT) || (r_state == RTS);
    assign ps2_d_oe   = (r_state == RTS);

    ps2_rx_holdreg u_hold (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .rx_ack   (rx_ack),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_ps2_link_sched.sv
// Self-checking bench for ps2_link_sched with timing derived
// arithmetically from the line-sequencing rules.
module tb_ps2_link_sched;

    localparam int INH  = 8;
    localparam int RTSC = 2;
    localparam int TMO  = 20;
    localparam int STC  = INH + RTSC + 1;
    localparam int PER  = INH + RTSC + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       fall_edge;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_ack;
    logic       tx_ack;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_idle;
    logic       ps2_c_oe;
    logic       ps2_d_oe;
    logic       resetCbits;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic [6:0] w_obs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign w_obs = {tx_ack, tx_start, tx_idle, ps2_c_oe,
                    ps2_d_oe, resetCbits, frame_err};

    ps2_link_sched #(
        .INHIBIT_CYC (INH),
        .RTS_CYC     (RTSC),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (17)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fall_edge  (fall_edge),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .tx_ack     (tx_ack),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_idle    (tx_idle),
        .ps2_c_oe   (ps2_c_oe),
        .ps2_d_oe   (ps2_d_oe),
        .resetCbits (resetCbits),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    task automatic clear_in();
        fall_edge = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        tx_req    = 1'b0;
        tx_data   = 8'h00;
        tx_done   = 1'b0;
        rx_ack    = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (w_obs !== 7'b0010000 || rx_valid !== 1'b0 || overrun !== 1'b0
            || rx_byte !== 8'h00 || tx_byte !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_vals: obs=%b rxv=%b ov=%b rxb=%h txb=%h want obs=0010000 rest 0",
                     w_obs, rx_valid, overrun, rx_byte, tx_byte);
        end
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'h5A;
        @(negedge clk);
        rx_done = 1'b0;
        tx_req  = 1'b1;
        tx_data = 8'h3C;
        #1;
        n_cmp++;
        if (rx_valid !== 1'b1 || tx_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre: rxv=%b ack=%b want 1 1", rx_valid, tx_ack);
        end
        @(negedge clk);
        tx_req = 1'b0;
        repeat (INH) @(negedge clk);
        #1;
        n_cmp++;
        if (ps2_c_oe !== 1'b1 || ps2_d_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_rts: c=%b d=%b want 1 1", ps2_c_oe, ps2_d_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== 7'b0010000 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_rts: obs=%b rxv=%b want 0010000 0", w_obs, rx_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_tx(input logic [7:0] d, input int dly, input bit fin);
        int         last;
        logic [6:0] exp;
        do_reset();
        last = STC + dly;
        for (int k = 0; k <= last + 1; k++) begin
            tx_req  = (k == 0);
            tx_data = (k == 0) ? d : 8'($urandom);
            tx_done = fin && (k == last);
            #1;
            exp = {k == 0, k == STC, k == 0 || k == last + 1,
                   k >= 1 && k <= INH + RTSC, k > INH && k <= INH + RTSC,
                   k == STC, !fin && k == last};
            n_cmp++;
            if (w_obs !== exp) begin
                n_bad++;
                $display("FAIL tx_seq k=%0d: obs=%b want %b", k, w_obs, exp);
            end
            if (k == STC) begin
                n_cmp++;
                if (tx_byte !== d) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h want %h", tx_byte, d);
                end
            end
            @(negedge clk);
        end
        clear_in();
    endtask

    task automatic test_rx(input int ne, input int sp,
                           input logic [7:0] d, input bit silent);
        int         eq[$];
        int         t;
        int         lst;
        int         endc;
        logic [6:0] exp;
        do_reset();
        t   = 0;
        lst = 0;
        for (int i = 0; i < ne; i++) begin
            eq.push_back(t);
            lst = t;
            t += (sp > 0) ? sp : int'($urandom_range(1, TMO - 1));
        end
        endc = silent ? lst + TMO : t;
        for (int k = 0; k <= endc + 1; k++) begin
            fall_edge = 1'b0;
            if (eq.size() > 0) begin
                if (eq[0] == k) begin
                    fall_edge = 1'b1;
                    void'(eq.pop_front());
                end
            end
            rx_done = !silent && (k == endc);
            rx_data = (k == endc) ? d : 8'($urandom);
            tx_req  = silent && (k == endc + 1);
            #1;
            exp = {silent && k == endc + 1, 1'b0, 1'b1, 1'b0, 1'b0,
                   silent && k == endc, silent && k == endc};
            n_cmp++;
            if (w_obs !== exp) begin
                n_bad++;
                $display("FAIL rx_seq k=%0d: obs=%b want %b", k, w_obs, exp);
            end
            if (!silent && k == endc + 1) begin
                n_cmp++;
                if (rx_byte !== d || rx_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rx_capture: byte=%h v=%b want %h 1", rx_byte, rx_valid, d);
                end
            end
            @(negedge clk);
        end
        clear_in();
        if (!silent) begin
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            #1;
            n_cmp++;
            if (rx_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rx_ack_clr: v=%b want 0", rx_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision(input logic [7:0] d);
        int         c;
        logic [6:0] exp;
        do_reset();
        c = int'($urandom_range(1, TMO - 2));
        tx_req  = 1'b1;
        tx_data = d;
        for (int k = 0; k <= c + 2; k++) begin
            fall_edge = (k == 0);
            rx_done   = (k == c);
            rx_data   = 8'($urandom);
            #1;
            exp = (k == c + 2) ? 7'b0001000 : {k == c + 1, 6'b010000};
            n_cmp++;
            if (w_obs !== exp) begin
                n_bad++;
                $display("FAIL collide k=%0d: obs=%b want %b", k, w_obs, exp);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (tx_byte !== d) begin
            n_bad++;
            $display("FAIL collide_byte: got %h want %h", tx_byte, d);
        end
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_back_to_back();
        int         m;
        logic [7:0] dq;
        logic [6:0] exp;
        do_reset();
        dq = 8'h00;
        for (int k = 0; k <= 3 * PER; k++) begin
            m       = k % PER;
            tx_req  = 1'b1;
            tx_data = 8'($urandom);
            tx_done = (m == STC);
            if (m == 0) dq = tx_data;
            #1;
            exp = {m == 0, m == STC, m == 0, m >= 1 && m <= INH + RTSC,
                   m > INH && m <= INH + RTSC, m == STC, 1'b0};
            n_cmp++;
            if (w_obs !== exp) begin
                n_bad++;
                $display("FAIL b2b k=%0d: obs=%b want %b", k, w_obs, exp);
            end
            if (m == STC) begin
                n_cmp++;
                if (tx_byte !== dq) begin
                    n_bad++;
                    $display("FAIL b2b_byte k=%0d: got %h want %h", k, tx_byte, dq);
                end
            end
            @(negedge clk);
        end
        clear_in();
    endtask

    task automatic test_holdreg();
        logic [7:0] lastb;
        int         unread;
        bit         rd;
        bit         ra;
        do_reset();
        lastb  = 8'h00;
        unread = 0;
        for (int k = 0; k < 80; k++) begin
            if (k < 3) begin
                rd = (k < 2);
                ra = (k == 2);
                rx_data = (k == 0) ? 8'h11 : 8'h22;
            end else begin
                rd = ($urandom_range(0, 2) == 0);
                ra = ($urandom_range(0, 3) == 0);
                rx_data = 8'($urandom);
            end
            rx_done   = rd;
            rx_ack    = ra;
            fall_edge = 1'b0;
            if (rd) lastb = rx_data;
            // Bytes held since the last read; more than one means one was lost.
            if (rd) unread = ra ? 1 : unread + 1;
            else if (ra) unread = 0;
            @(negedge clk);
            #1;
            n_cmp++;
            if (rx_byte !== lastb || rx_valid !== (unread > 0)
                || overrun !== (unread > 1)) begin
                n_bad++;
                $display("FAIL holdreg k=%0d: byte=%h v=%b ov=%b want %h %b %b",
                         k, rx_byte, rx_valid, overrun, lastb, unread > 0, unread > 1);
            end
        end
        clear_in();
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_tx(8'hED, TMO - 1, 1'b1);
        repeat (4) test_tx(8'($urandom), int'($urandom_range(0, TMO - 1)), 1'b1);
        test_tx(8'($urandom), TMO - 1, 1'b0);
        test_rx(11, 5, 8'hAA, 1'b0);
        repeat (3) test_rx(int'($urandom_range(1, 11)), 0, 8'($urandom), 1'b0);
        test_rx(3, 0, 8'($urandom), 1'b1);
        test_rx(3, 4, 8'($urandom), 1'b1);
        repeat (2) test_collision(8'($urandom));
        test_back_to_back();
        test_holdreg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
